// File: rtl/param_shift_parity_counter.sv
// Serial/parallel shift register with synchronised board inputs, a parity-event
// BCD counter and 7-segment decode of that count.
module param_shift_parity_counter #(
    parameter int WIDTH       = 10,
    parameter int DIGITS      = 2,
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1,
    parameter bit PARITY_ODD  = 1'b1,
    parameter bit COUNT_SAT   = 1'b0
) (
    input  logic                  CLOCK_50,
    input  logic [1:0]            KEY,
    input  logic [1:0]            SW,
    input  logic                  par_load,
    input  logic [WIDTH-1:0]      par_data,
    output logic [WIDTH-1:0]      shift_reg,
    output logic [WIDTH-1:0]      LEDR,
    output logic                  parity_even,
    output logic [4*DIGITS-1:0]   event_count,
    output logic                  count_tick,
    output logic [7*DIGITS-1:0]   HEX
);

    logic                   reset;
    logic [SYNC_STAGES-1:0] key_sync;
    logic [SYNC_STAGES-1:0] sd_sync;
    logic [SYNC_STAGES-1:0] dir_sync;
    logic                   key_sync_d;
    logic                   sync_k;
    logic                   sd;
    logic                   dir;
    logic                   shift_en;
    logic [WIDTH-1:0]       next_reg;
    logic                   update;
    logic                   parity_event;
    logic [4*DIGITS-1:0]    next_count;
    logic                   all_nines;
    logic                   carry;
    logic                   inc_ok;

    assign reset  = KEY[1];
    assign sync_k = key_sync[SYNC_STAGES-1];
    assign sd     = sd_sync[SYNC_STAGES-1];
    assign dir    = dir_sync[SYNC_STAGES-1];

    // Strobe and data share one chain depth so serial data stays aligned with its shift.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_sync   <= '0;
            sd_sync    <= '0;
            dir_sync   <= '0;
            key_sync_d <= 1'b0;
        end else begin
            key_sync   <= {key_sync[SYNC_STAGES-2:0], KEY[0]};
            sd_sync    <= {sd_sync[SYNC_STAGES-2:0], SW[0]};
            dir_sync   <= {dir_sync[SYNC_STAGES-2:0], SW[1]};
            key_sync_d <= sync_k;
        end
    end

    assign shift_en = EDGE_MODE ? (sync_k & ~key_sync_d) : sync_k;

    // A load drops any coincident shift outright rather than deferring it.
    always_comb begin
        next_reg = shift_reg;
        update   = 1'b0;
        if (par_load) begin
            next_reg = par_data;
            update   = 1'b1;
        end else if (shift_en) begin
            update = 1'b1;
            if (dir) next_reg = {sd, shift_reg[WIDTH-1:1]};
            else     next_reg = {shift_reg[WIDTH-2:0], sd};
        end
    end

    assign parity_event = update && ((^next_reg) == PARITY_ODD);

    always_comb begin
        next_count = event_count;
        all_nines  = 1'b1;
        carry      = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (event_count[4*i +: 4] != 4'd9) all_nines = 1'b0;
            if (carry) begin
                if (event_count[4*i +: 4] == 4'd9) begin
                    next_count[4*i +: 4] = 4'd0;
                end else begin
                    next_count[4*i +: 4] = event_count[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    assign inc_ok = parity_event && !(COUNT_SAT && all_nines);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            shift_reg   <= '0;
            LEDR        <= '0;
            event_count <= '0;
            count_tick  <= 1'b0;
        end else begin
            shift_reg  <= next_reg;
            LEDR       <= next_reg;
            count_tick <= inc_ok;
            if (inc_ok) event_count <= next_count;
        end
    end

    assign parity_even = ~^shift_reg;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        HEX = '1;
        for (int i = 0; i < DIGITS; i++) begin
            HEX[7*i +: 7] = seg7(event_count[4*i +: 4]);
        end
    end

endmodule

// File: tb/tb_param_shift_parity_counter.sv
// Directed bench for param_shift_parity_counter: wrap-mode instance plus a
// saturating instance driven by the same stimulus.
module tb_param_shift_parity_counter;

    logic        CLOCK_50 = 1'b0;
    logic [1:0]  KEY      = 2'b00;
    logic [1:0]  SW       = 2'b00;
    logic        par_load = 1'b0;
    logic [9:0]  par_data = '0;

    logic [9:0]  shift_reg, LEDR;
    logic        parity_even, count_tick;
    logic [7:0]  event_count;
    logic [13:0] HEX;

    logic [9:0]  sat_shift_reg, sat_ledr;
    logic        sat_parity_even, sat_tick;
    logic [7:0]  sat_count;
    logic [13:0] sat_hex;

    int vectors     = 0;
    int miscompares = 0;
    int ticks       = 0;
    int sat_ticks   = 0;
    logic [9:0] right_exp [3];

    always #5 CLOCK_50 = ~CLOCK_50;

    param_shift_parity_counter dut (
        .CLOCK_50(CLOCK_50), .KEY(KEY), .SW(SW), .par_load(par_load), .par_data(par_data),
        .shift_reg(shift_reg), .LEDR(LEDR), .parity_even(parity_even),
        .event_count(event_count), .count_tick(count_tick), .HEX(HEX)
    );

    param_shift_parity_counter #(.COUNT_SAT(1'b1)) dut_sat (
        .CLOCK_50(CLOCK_50), .KEY(KEY), .SW(SW), .par_load(par_load), .par_data(par_data),
        .shift_reg(sat_shift_reg), .LEDR(sat_ledr), .parity_even(sat_parity_even),
        .event_count(sat_count), .count_tick(sat_tick), .HEX(sat_hex)
    );

    task automatic step();
        @(posedge CLOCK_50);
        #1;
        if (count_tick) ticks++;
        if (sat_tick) sat_ticks++;
    endtask

    task automatic applyStimulus(input logic [1:0] key, input logic [1:0] sw,
                                 input logic load, input logic [9:0] data, input int cycles);
        KEY      = key;
        SW       = sw;
        par_load = load;
        par_data = data;
        for (int c = 0; c < cycles; c++) step();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        right_exp[0] = 10'h200;
        right_exp[1] = 10'h300;
        right_exp[2] = 10'h380;

        // Reset state
        applyStimulus(2'b10, 2'b00, 1'b0, 10'h000, 1);
        checkOutput("reset shift_reg", 32'(shift_reg), 32'h0);
        checkOutput("reset LEDR", 32'(LEDR), 32'h0);
        checkOutput("reset count", 32'(event_count), 32'h0);
        checkOutput("reset HEX", 32'(HEX), 32'(14'b1000000_1000000));
        checkOutput("reset tick", 32'(count_tick), 32'h0);
        checkOutput("reset parity_even", 32'(parity_even), 32'h1);
        applyStimulus(2'b00, 2'b00, 1'b0, 10'h000, 1);

        // Edge-mode left shift of a 1, KEY[0] held five cycles
        ticks = 0;
        applyStimulus(2'b01, 2'b01, 1'b0, 10'h000, 2);
        checkOutput("edge latency before N", 32'(shift_reg), 32'h0);
        step();
        checkOutput("edge shift at N", 32'(shift_reg), 32'h001);
        checkOutput("edge tick at N", 32'(count_tick), 32'h1);
        step();
        step();
        applyStimulus(2'b00, 2'b01, 1'b0, 10'h000, 3);
        checkOutput("edge single shift", 32'(shift_reg), 32'h001);
        checkOutput("edge LEDR", 32'(LEDR), 32'h001);
        checkOutput("edge count", 32'(event_count), 32'h01);
        checkOutput("edge HEX0", 32'(HEX[6:0]), 32'(7'b1111001));
        checkOutput("edge tick total", 32'(ticks), 32'd1);
        checkOutput("edge parity_even", 32'(parity_even), 32'h0);

        // Right shifts of 1s: odd, even, odd parity
        ticks = 0;
        for (int p = 0; p < 3; p++) begin
            applyStimulus(2'b01, 2'b11, 1'b0, 10'h000, 1);
            applyStimulus(2'b00, 2'b11, 1'b0, 10'h000, 3);
            checkOutput("right shift_reg", 32'(shift_reg), 32'(right_exp[p]));
        end
        checkOutput("right count", 32'(event_count), 32'h03);
        checkOutput("right ticks", 32'(ticks), 32'd2);

        // Load coinciding with shift_en: load wins, shift (right, sd=0) is dropped
        ticks = 0;
        applyStimulus(2'b01, 2'b10, 1'b0, 10'h000, 2);
        applyStimulus(2'b01, 2'b10, 1'b1, 10'h3FF, 1);
        applyStimulus(2'b00, 2'b10, 1'b0, 10'h000, 4);
        checkOutput("collision shift_reg", 32'(shift_reg), 32'h3FF);
        checkOutput("collision LEDR", 32'(LEDR), 32'h3FF);
        checkOutput("collision count", 32'(event_count), 32'h03);
        checkOutput("collision ticks", 32'(ticks), 32'd0);
        checkOutput("collision parity_even", 32'(parity_even), 32'h1);
        checkOutput("collision HEX0", 32'(HEX[6:0]), 32'(7'b0110000));

        // Counter up to 99, then wrap versus saturate
        applyStimulus(2'b10, 2'b00, 1'b0, 10'h000, 1);
        applyStimulus(2'b00, 2'b00, 1'b0, 10'h000, 1);
        ticks = 0;
        sat_ticks = 0;
        for (int n = 0; n < 99; n++) applyStimulus(2'b00, 2'b00, 1'b1, 10'h001, 1);
        applyStimulus(2'b00, 2'b00, 1'b0, 10'h000, 1);
        checkOutput("count 99", 32'(event_count), 32'h99);
        checkOutput("sat count 99", 32'(sat_count), 32'h99);
        checkOutput("HEX 99", 32'(HEX), 32'(14'b0010000_0010000));
        checkOutput("ticks 99", 32'(ticks), 32'd99);
        applyStimulus(2'b00, 2'b00, 1'b1, 10'h001, 1);
        checkOutput("wrap count", 32'(event_count), 32'h00);
        checkOutput("wrap tick", 32'(count_tick), 32'h1);
        checkOutput("wrap HEX", 32'(HEX), 32'(14'b1000000_1000000));
        checkOutput("sat hold count", 32'(sat_count), 32'h99);
        checkOutput("sat no tick", 32'(sat_tick), 32'h0);
        checkOutput("sat HEX", 32'(sat_hex), 32'(14'b0010000_0010000));
        applyStimulus(2'b00, 2'b00, 1'b0, 10'h000, 1);
        checkOutput("wrap tick one cycle", 32'(count_tick), 32'h0);
        checkOutput("sat tick total", 32'(sat_ticks), 32'd99);

        // Reset on the shift_en edge, KEY[0] held through release
        applyStimulus(2'b01, 2'b01, 1'b0, 10'h000, 2);
        applyStimulus(2'b11, 2'b01, 1'b0, 10'h000, 1);
        checkOutput("reset wins shift_reg", 32'(shift_reg), 32'h0);
        checkOutput("reset wins count", 32'(event_count), 32'h0);
        checkOutput("reset wins tick", 32'(count_tick), 32'h0);
        ticks = 0;
        applyStimulus(2'b01, 2'b01, 1'b0, 10'h000, 2);
        checkOutput("post-release before N", 32'(shift_reg), 32'h0);
        step();
        checkOutput("post-release shift at N", 32'(shift_reg), 32'h001);
        checkOutput("post-release count", 32'(event_count), 32'h01);
        applyStimulus(2'b01, 2'b01, 1'b0, 10'h000, 4);
        checkOutput("post-release single shift", 32'(shift_reg), 32'h001);
        checkOutput("post-release ticks", 32'(ticks), 32'd1);
        checkOutput("post-release LEDR", 32'(LEDR), 32'h001);
        applyStimulus(2'b00, 2'b00, 1'b0, 10'h000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
